vga_linefetch: RTL and testbench

- Bitmap prefetcher directly upstream of the 640x480 mono VGA/HDMI output stage.
- Answers that stage's dispAddr/dispData byte-read port from an on-chip ring buffer.
- Fills the ring by fetching 32-bit words from main memory over the f32c-style strobe/ack bus.
- Lets the framebuffer live in shared RAM instead of a dedicated video BRAM.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_linefetch_if.sv | 13 +
 rtl/vga_ring_ram.sv | 34 +++
 rtl/vga_linefetch.sv | 110 +++++++++++
 tb/tb_vga_linefetch.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the mono VGA bitmap prefetcher.
package vga_pkg;

    localparam int H_VISIBLE      = 640;
    localparam int V_VISIBLE      = 480;
    localparam int BYTES_PER_LINE = 80;

    localparam int MEM_ADDR_W = 30;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/vga_linefetch_if.sv
// Strobe/ack word-read bus between the line fetcher (master) and main memory (slave).
interface vga_linefetch_if;
    import vga_pkg::*;

    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_strobe;
    logic                  mem_ack;
    logic [MEM_DATA_W-1:0] mem_data;

    modport master (output mem_addr, mem_strobe, input mem_ack, mem_data);
    modport slave  (input mem_addr, mem_strobe, output mem_ack, mem_data);

endinterface

// File: rtl/vga_ring_ram.sv
// Ring buffer storage: 32-bit word writes, registered little-endian byte reads.
module vga_ring_ram
    import vga_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [MEM_DATA_W-1:0] wr_data,
    input  logic [ADDR_W+1:0]     rd_addr,
    output logic [7:0]            rd_data
);

    logic [MEM_DATA_W-1:0] mem [2**ADDR_W];
    logic [MEM_DATA_W-1:0] rd_word;

    // NOTE: the array itself is never reset; a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_word = mem[rd_addr[ADDR_W+1:2]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= rd_word[8*rd_addr[1:0] +: 8];
    end

endmodule

// File: rtl/vga_linefetch.sv
// Prefetches the frame bitmap from shared RAM into a ring that serves the display's byte reads.
module vga_linefetch
    import vga_pkg::*;
#(
    parameter int RING_LOG2   = 6,
    parameter int KEEP_BYTES  = 80,
    parameter int FRAME_BYTES = 4096
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic                  vsync,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    input  logic [15:0]           dispAddr,
    output logic [7:0]            dispData,
    output logic                  underrun,
    vga_linefetch_if.master       bus
);

    localparam int RING_BYTES = 2**(RING_LOG2+2);

    fetch_state_t          state, state_next;
    logic [16:0]           fetch_bytes, fetch_bytes_next;
    logic [MEM_ADDR_W-1:0] frame_base, frame_base_next;
    logic                  vsync_d, flush_req, flush_req_next, underrun_next;
    logic                  vsync_rise, flush_pending, need, uncovered, ring_we;
    logic [16:0]           disp_ext, rd_low;

    assign vsync_rise    = vsync & ~vsync_d;
    assign flush_pending = flush_req | vsync_rise;

    // Oldest byte the display may still revisit; everything below it may be overwritten.
    assign disp_ext = {1'b0, dispAddr};
    assign rd_low   = (disp_ext >= 17'(KEEP_BYTES)) ? disp_ext - 17'(KEEP_BYTES) : '0;
    assign need     = (fetch_bytes < 17'(FRAME_BYTES)) &&
                      (fetch_bytes + 17'd4 <= rd_low + 17'(RING_BYTES));
    assign uncovered = (disp_ext >= fetch_bytes) && (disp_ext < 17'(FRAME_BYTES));

    assign bus.mem_strobe = (state == REQ);
    assign bus.mem_addr   = frame_base + MEM_ADDR_W'(fetch_bytes[16:2]);

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_next       = state;
        fetch_bytes_next = fetch_bytes;
        frame_base_next  = frame_base;
        flush_req_next   = flush_pending;
        underrun_next    = underrun | uncovered;
        ring_we          = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pending)
                    state_next = FLUSH;
                else if (need)
                    state_next = REQ;
            end
            REQ: begin
                // The request stays up until acked; a pending flush only drops the returned word.
                if (bus.mem_ack) begin
                    if (flush_pending) begin
                        state_next = FLUSH;
                    end else begin
                        ring_we          = 1'b1;
                        fetch_bytes_next = fetch_bytes + 17'd4;
                        state_next       = IDLE;
                    end
                end
            end
            FLUSH: begin
                fetch_bytes_next = '0;
                frame_base_next  = base_addr;
                underrun_next    = 1'b0;
                flush_req_next   = 1'b0;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_bytes <= '0;
            frame_base  <= '0;
            vsync_d     <= 1'b0;
            flush_req   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_bytes <= fetch_bytes_next;
            frame_base  <= frame_base_next;
            vsync_d     <= vsync;
            flush_req   <= flush_req_next;
            underrun    <= underrun_next;
        end
    end

    vga_ring_ram #(
        .ADDR_W (RING_LOG2)
    ) u_ring (
        .clk     (clk_pixel),
        .rst_n   (reset_n),
        .wr_en   (ring_we),
        .wr_addr (fetch_bytes[RING_LOG2+1:2]),
        .wr_data (bus.mem_data),
        .rd_addr (dispAddr[RING_LOG2+1:0]),
        .rd_data (dispData)
    );

endmodule

// File: tb/tb_vga_linefetch.sv
// Directed bench for vga_linefetch with a behavioural strobe/ack memory.
module tb_vga_linefetch;
    import vga_pkg::*;

    logic        clk_pixel = 1'b0;
    logic        reset_n   = 1'b0;
    logic        vsync     = 1'b0;
    logic [29:0] base_addr = '0;
    logic [15:0] dispAddr  = '0;
    logic [7:0]  dispData;
    logic        underrun;

    vga_linefetch_if bus ();

    vga_linefetch dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .vsync     (vsync),
        .base_addr (base_addr),
        .dispAddr  (dispAddr),
        .dispData  (dispData),
        .underrun  (underrun),
        .bus       (bus.master)
    );

    always #20 clk_pixel = ~clk_pixel;

    int checks   = 0;
    int failures = 0;

    bit          hold      = 1'b0;
    int          ack_delay = 1;
    int          wait_cnt  = 0;
    int          stab_err  = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_ack    = 1'b0;
    logic [29:0] prev_addr   = '0;
    logic [29:0] req_log [$];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h1000)
            return 32'hDDCC_BBAA;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [29:0] base, input int off);
        logic [31:0] w;
        w = mem_word(base + 30'(off / 4));
        return w[8*(off % 4) +: 8];
    endfunction

    // Memory slave: acks after ack_delay strobe cycles unless held, and checks request stability.
    always @(negedge clk_pixel) begin
        if (!reset_n) begin
            bus.mem_ack  = 1'b0;
            bus.mem_data = '0;
            wait_cnt     = 0;
            prev_strobe  = 1'b0;
            prev_ack     = 1'b0;
        end else begin
            if (prev_strobe && !prev_ack &&
                (!bus.mem_strobe || bus.mem_addr != prev_addr))
                stab_err++;
            bus.mem_ack = 1'b0;
            if (bus.mem_strobe) begin
                wait_cnt++;
                if (!hold && wait_cnt >= ack_delay) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = mem_word(bus.mem_addr);
                    req_log.push_back(bus.mem_addr);
                end
            end else begin
                wait_cnt = 0;
            end
            prev_strobe = bus.mem_strobe;
            prev_addr   = bus.mem_addr;
            prev_ack    = bus.mem_ack;
        end
    end

    task automatic step();
        @(negedge clk_pixel);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        for (int i = 0; i < 64 && !bus.mem_strobe; i++)
            step();
        check(tag, 32'(bus.mem_strobe), 32'd1);
    endtask

    task automatic wait_ack(input string tag, input logic [29:0] addr);
        for (int i = 0; i < 300 && !(bus.mem_ack && bus.mem_addr == addr); i++)
            step();
        check(tag, 32'(bus.mem_ack && bus.mem_addr == addr), 32'd1);
    endtask

    // Starts a frame at base; dispAddr is parked past the frame until two words are in.
    task automatic new_frame(input logic [29:0] base);
        ack_delay = 1;
        hold      = 1'b0;
        dispAddr  = 16'hFFFF;
        base_addr = base;
        vsync     = 1'b1;
        step();
        vsync = 1'b0;
        wait_ack("nf_second_word", base + 30'd1);
        step();
        dispAddr = '0;
        repeat (200) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] order_exp [4];
        int  first_seen, data_err, addr_err, ur_err, mark, fb, strobe_hi;
        bit  pred;

        order_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // Reset state, then prefill of the frame at 0x1000.
        vsync     = 1'b1;
        dispAddr  = 16'hFFFF;
        base_addr = 30'h1000;
        repeat (3) step();
        check("rst_dispData", 32'(dispData), 32'h0);
        check("rst_strobe", 32'(bus.mem_strobe), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        reset_n = 1'b1;
        step();
        vsync = 1'b0;
        wait_ack("pf_second_word", 30'h1001);
        step();
        dispAddr = '0;
        repeat (200) step();
        check("pf_req_count", 32'(req_log.size()), 32'd64);
        addr_err = 0;
        for (int i = 0; i < req_log.size() && i < 64; i++)
            if (req_log[i] != 30'h1000 + 30'(i)) addr_err++;
        check("pf_req_addrs", 32'(addr_err), 32'd0);
        check("pf_fetch_bytes", 32'(dut.fetch_bytes), 32'd256);
        strobe_hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_strobe) strobe_hi++;
        end
        check("pf_idle_strobe", 32'(strobe_hi), 32'd0);
        check("pf_underrun", 32'(underrun), 32'd0);

        // Byte order and one-cycle read latency.
        for (int k = 0; k < 4; k++) begin
            dispAddr = 16'(k);
            step();
            check($sformatf("byte_order_%0d", k), 32'(dispData), 32'(order_exp[k]));
        end
        dispAddr = 16'd83;
        step();
        check("byte_83", 32'(dispData), 32'(exp_byte(30'h1000, 83)));
        step();
        check("no_fetch_at_83", 32'(bus.mem_strobe), 32'd0);

        // Window advance: one byte per 8 cycles over the first ring's worth.
        first_seen = -1;
        data_err   = 0;
        for (int a = 0; a < 256; a++) begin
            dispAddr = 16'(a);
            for (int k = 0; k < 8; k++) begin
                step();
                if (k == 0 && dispData !== exp_byte(30'h1000, a)) data_err++;
                if (bus.mem_strobe && first_seen < 0) first_seen = a;
            end
        end
        check("win_first_fetch_at", 32'(first_seen), 32'd84);
        check("win_read_data", 32'(data_err), 32'd0);
        check("win_fetch_bytes", 32'(dut.fetch_bytes), 32'd428);
        check("win_req_count", 32'(req_log.size()), 32'd107);
        check("win_last_addr", 32'(req_log[req_log.size()-1]), 32'h106A);
        dispAddr = 16'd176;
        step();
        check("win_step_back", 32'(dispData), 32'(exp_byte(30'h1000, 176)));
        dispAddr = 16'd300;
        step();
        check("win_wrapped_word", 32'(dispData), 32'(exp_byte(30'h1000, 300)));
        check("win_underrun", 32'(underrun), 32'd0);

        // Slow bus: reads overtake the fetcher.
        new_frame(30'h2000);
        ack_delay = 40;
        mark      = req_log.size();
        pred      = 1'b0;
        ur_err    = 0;
        for (int d = 0; d <= 300; d++) begin
            dispAddr = 16'(d);
            fb = 256 + 4 * (req_log.size() - mark - (bus.mem_ack ? 1 : 0));
            if (d >= fb && d < 4096) pred = 1'b1;
            step();
            if (underrun !== pred) ur_err++;
        end
        check("slow_underrun_track", 32'(ur_err), 32'd0);
        check("slow_underrun_final", 32'(underrun), 32'd1);
        check("slow_req_stable", 32'(stab_err), 32'd0);
        new_frame(30'h2400);
        check("vsync_clears_underrun", 32'(underrun), 32'd0);

        // Flush while a request waits for its ack.
        hold     = 1'b1;
        dispAddr = 16'd84;
        wait_strobe("fr_strobe");
        check("fr_req_addr", 32'(bus.mem_addr), 32'h2440);
        vsync     = 1'b1;
        base_addr = 30'h3000;
        step();
        vsync = 1'b0;
        repeat (4) step();
        check("fr_strobe_held", 32'(bus.mem_strobe), 32'd1);
        hold = 1'b0;
        wait_ack("fr_ack", 30'h2440);
        hold     = 1'b1;
        dispAddr = 16'hFFFF;
        step();
        check("fr_state_flush", 32'(dut.state), 32'(FLUSH));
        check("fr_fb_kept", 32'(dut.fetch_bytes), 32'd256);
        step();
        check("fr_fb_cleared", 32'(dut.fetch_bytes), 32'd0);
        step();
        check("fr_new_strobe", 32'(bus.mem_strobe), 32'd1);
        check("fr_new_addr", 32'(bus.mem_addr), 32'h3000);
        dispAddr = '0;
        step();
        check("fr_not_written", 32'(dispData), 32'(exp_byte(30'h2400, 0)));
        check("fr_stale_underrun", 32'(underrun), 32'd1);

        // Vsync rising in the same cycle as the ack.
        new_frame(30'h3400);
        hold     = 1'b1;
        dispAddr = 16'd84;
        wait_strobe("co_strobe");
        check("co_req_addr", 32'(bus.mem_addr), 32'h3440);
        hold = 1'b0;
        wait_ack("co_ack", 30'h3440);
        vsync     = 1'b1;
        base_addr = 30'h4000;
        hold      = 1'b1;
        dispAddr  = 16'hFFFF;
        step();
        vsync = 1'b0;
        check("co_state_flush", 32'(dut.state), 32'(FLUSH));
        check("co_fb_kept", 32'(dut.fetch_bytes), 32'd256);
        step();
        step();
        check("co_new_strobe", 32'(bus.mem_strobe), 32'd1);
        check("co_new_addr", 32'(bus.mem_addr), 32'h4000);
        dispAddr = '0;
        step();
        check("co_not_written", 32'(dispData), 32'(exp_byte(30'h3400, 0)));

        // Asynchronous reset in the middle of a held request.
        check("ar_pre_underrun", 32'(underrun), 32'd1);
        reset_n = 1'b0;
        #1;
        check("ar_strobe", 32'(bus.mem_strobe), 32'd0);
        check("ar_dispData", 32'(dispData), 32'd0);
        check("ar_underrun", 32'(underrun), 32'd0);
        check("ar_mem_addr", 32'(bus.mem_addr), 32'd0);
        step();
        step();
        hold    = 1'b0;
        reset_n = 1'b1;
        wait_strobe("ar_restart_strobe");
        check("ar_restart_addr", 32'(bus.mem_addr), 32'h0);
        repeat (10) step();
        check("final_req_stable", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
